// File: rtl/str_pkg.sv
// Shared types and constants for the symbol timing recovery sequencer.
package str_pkg;

  // Width of the signed Gardner TED error word.
  localparam int ER_W = 32;

  // Sequencer phases; the encoding is visible on the state port.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_ACQ   = 2'd2,
    ST_TRACK = 2'd3
  } str_state_e;

  // Default PI gain right-shifts for acquisition and tracking.
  localparam int KP_ACQ_DEF = 4;
  localparam int KI_ACQ_DEF = 10;
  localparam int KP_TRK_DEF = 7;
  localparam int KI_TRK_DEF = 14;

  // Magnitude of a two's complement error. The most negative value has no
  // positive counterpart, so it saturates to the largest positive value
  // instead of wrapping back to itself.
  function automatic logic [ER_W-1:0] abs_sat(input logic [ER_W-1:0] x);
    logic [ER_W-1:0] neg_x;
    neg_x = (~x) + ER_W'(1);
    if (!x[ER_W-1]) begin
      return x;
    end else if (x == {1'b1, {(ER_W-1){1'b0}}}) begin
      return {1'b0, {(ER_W-1){1'b1}}};
    end else begin
      return neg_x;
    end
  endfunction

endpackage

// File: rtl/str_run_counter.sv
// Classifies each TED error as good or bad and tracks the current run of
// consecutive good symbols (for lock) and bad symbols (for unlock).
// The parent clears both runs on every state entry.
module str_run_counter
  import str_pkg::*;
#(
  parameter int LOCK_THRESH  = 4096,
  parameter int LOCK_COUNT   = 64,
  parameter int UNLOCK_COUNT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            good_en,
  input  logic            bad_en,
  input  logic [ER_W-1:0] er,
  output logic            lock_hit,
  output logic            unlock_hit
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_COUNT + 1);
  localparam logic [GW-1:0]   GOOD_MAX = GW'(LOCK_COUNT);
  localparam logic [BW-1:0]   BAD_MAX  = BW'(UNLOCK_COUNT);
  localparam logic [ER_W-1:0] THRESH   = ER_W'(LOCK_THRESH);

  logic [ER_W-1:0] er_mag;
  logic            is_good;
  logic [GW-1:0]   good_cnt, good_nxt;
  logic [BW-1:0]   bad_cnt, bad_nxt;

  // Classify the current error and compute the saturating next run lengths.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    er_mag   = abs_sat(er);
    is_good  = (er_mag <= THRESH);
    good_nxt = '0;
    bad_nxt  = '0;
    if (is_good) begin
      good_nxt = (good_cnt == GOOD_MAX) ? good_cnt : good_cnt + GW'(1);
    end else begin
      bad_nxt = (bad_cnt == BAD_MAX) ? bad_cnt : bad_cnt + BW'(1);
    end
    lock_hit   = good_en && is_good && (good_nxt == GOOD_MAX);
    unlock_hit = bad_en && !is_good && (bad_nxt == BAD_MAX);
  end

  // Run counters advance only on qualified error events; clear wins.
  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      if (good_en) good_cnt <= good_nxt;
      if (bad_en)  bad_cnt  <= bad_nxt;
    end
  end

endmodule

// File: rtl/str_loop_sequencer.sv
// Acquisition/tracking controller for the symbol timing recovery loop.
// Paces ADC sampling, holds the loop during the startup flush, selects PI
// gain shifts per phase and declares/drops timing lock from TED errors.
module str_loop_sequencer
  import str_pkg::*;
#(
  parameter int SAMPLE_DIV   = 10,
  parameter int FLUSH_SYMS   = 16,
  parameter int LOCK_THRESH  = 4096,
  parameter int LOCK_COUNT   = 64,
  parameter int UNLOCK_COUNT = 16,
  parameter int ACQ_TIMEOUT  = 4096,
  parameter int KP_ACQ       = KP_ACQ_DEF,
  parameter int KI_ACQ       = KI_ACQ_DEF,
  parameter int KP_TRK       = KP_TRK_DEF,
  parameter int KI_TRK       = KI_TRK_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            strobe,
  input  logic            ted_out_en,
  input  logic [ER_W-1:0] er,
  output logic            sample_en,
  output logic            loop_hold,
  output logic [4:0]      kp_shift,
  output logic [4:0]      ki_shift,
  output logic            locked,
  output logic [1:0]      state,
  output logic            acq_timeout
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_FLUSH = ST_FLUSH;
  localparam logic [1:0] S_ACQ   = ST_ACQ;
  localparam logic [1:0] S_TRACK = ST_TRACK;

  localparam int PW = $clog2(SAMPLE_DIV + 1);
  localparam int FW = $clog2(FLUSH_SYMS + 1);
  localparam int SW = $clog2(ACQ_TIMEOUT + 1);
  localparam logic [PW-1:0] PACE_LAST = PW'(SAMPLE_DIV - 1);
  localparam logic [FW-1:0] FLUSH_MAX = FW'(FLUSH_SYMS);
  localparam logic [SW-1:0] SYM_MAX   = SW'(ACQ_TIMEOUT);

  logic [1:0]    state_q, state_nxt;
  logic [PW-1:0] pace_cnt;
  logic [FW-1:0] flush_cnt, flush_nxt, flush_inc;
  logic [SW-1:0] sym_cnt, sym_nxt, sym_inc;
  logic          ato_nxt;
  logic          entry;
  logic          acq_evt, trk_evt;
  logic          lock_hit, unlock_hit;

  // A qualified error event exists only in the states that consume it.
  assign acq_evt = ted_out_en && (state_q == S_ACQ);
  assign trk_evt = ted_out_en && (state_q == S_TRACK);

  str_run_counter #(
    .LOCK_THRESH  (LOCK_THRESH),
    .LOCK_COUNT   (LOCK_COUNT),
    .UNLOCK_COUNT (UNLOCK_COUNT)
  ) u_run (
    .clk        (clk),
    .reset      (reset),
    .clear      (entry),
    .good_en    (acq_evt),
    .bad_en     (trk_evt),
    .er         (er),
    .lock_hit   (lock_hit),
    .unlock_hit (unlock_hit)
  );

  // ADC pacing: free-running divider while enabled, one-cycle pulse at wrap.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      pace_cnt  <= '0;
      sample_en <= 1'b0;
    end else begin
      sample_en <= (pace_cnt == PACE_LAST);
      pace_cnt  <= (pace_cnt == PACE_LAST) ? '0 : pace_cnt + PW'(1);
    end
  end

  // Next-state logic; lock beats timeout, and enable low overrides everything.
  always_comb begin
    state_nxt = state_q;
    ato_nxt   = 1'b0;
    flush_inc = (flush_cnt == FLUSH_MAX) ? flush_cnt : flush_cnt + FW'(1);
    sym_inc   = (sym_cnt == SYM_MAX) ? sym_cnt : sym_cnt + SW'(1);
    flush_nxt = flush_cnt;
    sym_nxt   = sym_cnt;
    case (state_q)
      S_IDLE: begin
        if (enable) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (strobe) begin
          flush_nxt = flush_inc;
          if (flush_inc == FLUSH_MAX) state_nxt = S_ACQ;
        end
      end
      S_ACQ: begin
        if (ted_out_en) begin
          sym_nxt = sym_inc;
          if (lock_hit) begin
            state_nxt = S_TRACK;
          end else if (sym_inc == SYM_MAX) begin
            state_nxt = S_FLUSH;
            ato_nxt   = 1'b1;
          end
        end
      end
      S_TRACK: begin
        if (unlock_hit) state_nxt = S_ACQ;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (!enable) begin
      state_nxt = S_IDLE;
      ato_nxt   = 1'b0;
    end
  end

  // Any state change (or a disable) starts the new phase with clean counters.
  assign entry = (state_nxt != state_q) || !enable;

  // State register, phase counters and timeout pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      flush_cnt   <= '0;
      sym_cnt     <= '0;
      acq_timeout <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      acq_timeout <= ato_nxt;
      if (entry) begin
        flush_cnt <= '0;
        sym_cnt   <= '0;
      end else begin
        flush_cnt <= flush_nxt;
        sym_cnt   <= sym_nxt;
      end
    end
  end

  // Moore outputs decoded straight from the state register.
  always_comb begin
    loop_hold = 1'b1;
    kp_shift  = 5'(KP_ACQ);
    ki_shift  = 5'(KI_ACQ);
    locked    = 1'b0;
    case (state_q)
      S_ACQ: loop_hold = 1'b0;
      S_TRACK: begin
        loop_hold = 1'b0;
        kp_shift  = 5'(KP_TRK);
        ki_shift  = 5'(KI_TRK);
        locked    = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_str_loop_sequencer.sv
// Directed bench for str_loop_sequencer. Stimulus pushes the expected
// output snapshot for each cycle of interest into a scoreboard queue; a
// separate monitor pops and compares on the falling edge of that cycle.
module tb_str_loop_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        strobe = 1'b0;
  logic        ted_out_en = 1'b0;
  logic [31:0] er = '0;
  logic        sample_en, loop_hold, locked, acq_timeout;
  logic [4:0]  kp_shift, ki_shift;
  logic [1:0]  state;

  str_loop_sequencer #(
    .SAMPLE_DIV   (10),
    .FLUSH_SYMS   (4),
    .LOCK_THRESH  (4096),
    .LOCK_COUNT   (8),
    .UNLOCK_COUNT (3),
    .ACQ_TIMEOUT  (20),
    .KP_ACQ       (4),
    .KI_ACQ       (10),
    .KP_TRK       (7),
    .KI_TRK       (14)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .strobe      (strobe),
    .ted_out_en  (ted_out_en),
    .er          (er),
    .sample_en   (sample_en),
    .loop_hold   (loop_hold),
    .kp_shift    (kp_shift),
    .ki_shift    (ki_shift),
    .locked      (locked),
    .state       (state),
    .acq_timeout (acq_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      name;
    logic [1:0] st;
    logic       hold;
    logic [4:0] kp;
    logic [4:0] ki;
    logic       lk;
    logic       ato;
    logic       chk_se;
    logic       se;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [14:0] got, input logic [14:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Expected Moore outputs per state: IDLE/FLUSH hold the loop, TRACK uses
  // tracking gains and reports lock.
  task automatic expect_st(input string name, input logic [1:0] st, input logic ato,
                           input logic chk_se, input logic se);
    exp_t e;
    e.cyc    = cyc;
    e.name   = name;
    e.st     = st;
    e.hold   = (st == 2'd0) || (st == 2'd1);
    e.kp     = (st == 2'd3) ? 5'd7 : 5'd4;
    e.ki     = (st == 2'd3) ? 5'd14 : 5'd10;
    e.lk     = (st == 2'd3);
    e.ato    = ato;
    e.chk_se = chk_se;
    e.se     = se;
    sb.push_back(e);
  endtask

  // Monitor: compare every snapshot scheduled for the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      check(mon_e.name,
            {state, loop_hold, kp_shift, ki_shift, locked, acq_timeout},
            {mon_e.st, mon_e.hold, mon_e.kp, mon_e.ki, mon_e.lk, mon_e.ato});
      if (mon_e.chk_se) check({mon_e.name, "/sample_en"}, 15'(sample_en), 15'(mon_e.se));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe_pulse();
    strobe = 1'b1;
    tick(1);
    strobe = 1'b0;
  endtask

  task automatic ted(input logic [31:0] v);
    ted_out_en = 1'b1;
    er         = v;
    tick(1);
    ted_out_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle.
    reset = 1'b1;
    tick(2);
    expect_st("reset", 2'd0, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    tick(2);
    expect_st("idle_disabled", 2'd0, 1'b0, 1'b1, 1'b0);

    // Enable: FLUSH next edge, sample pacing first pulse 10 edges later.
    enable = 1'b1;
    tick(1);
    expect_st("flush_entry", 2'd1, 1'b0, 1'b1, 1'b0);
    tick(8);
    expect_st("pace_edge9", 2'd1, 1'b0, 1'b1, 1'b0);
    tick(1);
    expect_st("pace_edge10", 2'd1, 1'b0, 1'b1, 1'b1);
    tick(1);
    expect_st("pace_edge11", 2'd1, 1'b0, 1'b1, 1'b0);
    tick(9);
    expect_st("pace_edge20", 2'd1, 1'b0, 1'b1, 1'b1);

    // FLUSH: three strobes stay; errors ignored; the fourth strobe enters ACQ.
    for (int i = 0; i < 3; i++) begin
      strobe_pulse();
      expect_st("flush_strobe", 2'd1, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 8; i++) ted(32'd100);
    expect_st("flush_ignores_ted", 2'd1, 1'b0, 1'b0, 1'b0);
    strobe_pulse();
    expect_st("flush_to_acq", 2'd2, 1'b0, 1'b0, 1'b0);

    // ACQ: 4 good, one bad (-5000) restarts the run, 8 more good lock.
    for (int i = 0; i < 4; i++) begin
      ted(32'd100);
      expect_st("acq_good_a", 2'd2, 1'b0, 1'b0, 1'b0);
    end
    ted(-32'sd5000);
    expect_st("acq_bad_neg", 2'd2, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      ted(32'd100);
      expect_st("acq_good_b", 2'd2, 1'b0, 1'b0, 1'b0);
    end
    ted(32'd100);
    expect_st("acq_to_track", 2'd3, 1'b0, 1'b0, 1'b0);

    // TRACK: bad, bad, good, bad, bad stays locked; good, then 3 bad unlocks.
    ted(32'd5000);  expect_st("trk_bad1", 2'd3, 1'b0, 1'b0, 1'b0);
    ted(32'd5000);  expect_st("trk_bad2", 2'd3, 1'b0, 1'b0, 1'b0);
    ted(32'd0);     expect_st("trk_good", 2'd3, 1'b0, 1'b0, 1'b0);
    ted(32'd5000);  expect_st("trk_bad3", 2'd3, 1'b0, 1'b0, 1'b0);
    ted(32'd5000);  expect_st("trk_bad4", 2'd3, 1'b0, 1'b0, 1'b0);
    ted(32'd0);     expect_st("trk_good2", 2'd3, 1'b0, 1'b0, 1'b0);
    ted(32'd5000);  expect_st("trk_run1", 2'd3, 1'b0, 1'b0, 1'b0);
    ted(32'd5000);  expect_st("trk_run2", 2'd3, 1'b0, 1'b0, 1'b0);
    ted(32'd5000);  expect_st("trk_unlock", 2'd2, 1'b0, 1'b0, 1'b0);

    // ACQ magnitude boundaries: -2^31 is bad, +/-4096 are good.
    for (int i = 0; i < 3; i++) begin
      ted(32'd100);
      expect_st("acq_pre_min", 2'd2, 1'b0, 1'b0, 1'b0);
    end
    ted(32'h8000_0000);
    expect_st("acq_min_neg_bad", 2'd2, 1'b0, 1'b0, 1'b0);
    ted(32'd4096);
    expect_st("acq_pos_thresh", 2'd2, 1'b0, 1'b0, 1'b0);
    ted(-32'sd4096);
    expect_st("acq_neg_thresh", 2'd2, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      ted(32'd100);
      expect_st("acq_good_c", 2'd2, 1'b0, 1'b0, 1'b0);
    end
    ted(32'd100);
    expect_st("acq_lock_c", 2'd3, 1'b0, 1'b0, 1'b0);

    // Back to ACQ, then 20 bad symbols time out to FLUSH with a single pulse.
    for (int i = 0; i < 3; i++) ted(32'd5000);
    expect_st("trk_unlock2", 2'd2, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 19; i++) begin
      ted(32'd5000);
      expect_st("acq_pre_timeout", 2'd2, 1'b0, 1'b0, 1'b0);
    end
    ted(32'd5000);
    expect_st("acq_timeout", 2'd1, 1'b1, 1'b0, 1'b0);
    tick(1);
    expect_st("acq_timeout_end", 2'd1, 1'b0, 1'b0, 1'b0);

    // Flush counter restarts: four fresh strobes needed.
    for (int i = 0; i < 3; i++) begin
      strobe_pulse();
      expect_st("reflush_strobe", 2'd1, 1'b0, 1'b0, 1'b0);
    end
    strobe_pulse();
    expect_st("reflush_to_acq", 2'd2, 1'b0, 1'b0, 1'b0);

    // Lock and timeout on the same (20th) event: lock wins.
    for (int i = 0; i < 12; i++) ted(32'd5000);
    for (int i = 0; i < 7; i++) ted(32'd100);
    expect_st("acq_event19", 2'd2, 1'b0, 1'b0, 1'b0);
    ted(32'd100);
    expect_st("lock_beats_timeout", 2'd3, 1'b0, 1'b0, 1'b0);

    // Disable in TRACK with a coincident error event: IDLE next edge.
    enable = 1'b0;
    ted(32'd5000);
    expect_st("disable_to_idle", 2'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick(1);
      expect_st("disabled_no_pace", 2'd0, 1'b0, 1'b1, 1'b0);
    end

    // Re-enable, reach ACQ, then reset mid-ACQ.
    enable = 1'b1;
    tick(1);
    expect_st("reenable_flush", 2'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) strobe_pulse();
    expect_st("reenable_acq", 2'd2, 1'b0, 1'b0, 1'b0);
    ted(32'd100);
    ted(32'd100);
    reset = 1'b1;
    tick(1);
    expect_st("reset_mid_acq", 2'd0, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    tick(1);
    expect_st("post_reset_flush", 2'd1, 1'b0, 1'b1, 1'b0);
    tick(8);
    expect_st("post_reset_pace9", 2'd1, 1'b0, 1'b1, 1'b0);
    tick(1);
    expect_st("post_reset_pace10", 2'd1, 1'b0, 1'b1, 1'b1);

    tick(2);
    check("scoreboard_drained", 15'(sb.size()), 15'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/str_loop_sequencer.md
Name: str_loop_sequencer

Overview:
- Acquisition/tracking controller for the symbol timing recovery loop: interpolators, Gardner TED, PI loop filter and NCO.
- Generates the ADC sample pacing enable: 100 MHz clock, one sample per SAMPLE_DIV clocks.
- Holds the loop during startup flush and selects PI gain shifts for the acquisition and tracking phases.
- Declares timing lock from TED error magnitude; drops lock when error persistently exceeds threshold.

Parameters:
SAMPLE_DIV, 10, clocks per ADC sample pulse
FLUSH_SYMS, 16, strobes to wait in FLUSH before enabling loop
LOCK_THRESH, 4096, unsigned |er| threshold for a "good" symbol
LOCK_COUNT, 64, consecutive good symbols to declare lock
UNLOCK_COUNT, 16, consecutive bad symbols in TRACK to drop lock
ACQ_TIMEOUT, 4096, ted_out_en events allowed in ACQ before re-flush
KP_ACQ, 4, proportional right-shift in acquisition
KI_ACQ, 10, integral right-shift in acquisition
KP_TRK, 7, proportional right-shift in tracking
KI_TRK, 14, integral right-shift in tracking

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  synchronous, active-high reset
enable  in  1  run request; low forces IDLE
strobe  in  1  NCO symbol strobe
ted_out_en  in  1  TED error valid, one per symbol
er  in  32  signed TED error
sample_en  out  1  one-cycle ADC sample pacing pulse
loop_hold  out  1  freeze loop filter integrator and NCO update
kp_shift  out  5  active proportional shift
ki_shift  out  5  active integral shift
locked  out  1  timing lock indication
state  out  2  IDLE=0, FLUSH=1, ACQ=2, TRACK=3
acq_timeout  out  1  one-cycle pulse on ACQ timeout

Behaviour:
- Reset values: state IDLE, sample_en 0, loop_hold 1, kp_shift KP_ACQ, ki_shift KI_ACQ, locked 0, acq_timeout 0, all counters 0.
- Pacing counter runs 0..SAMPLE_DIV-1 while enable=1.
  - sample_en=1 exactly when counter==SAMPLE_DIV-1, i.e. the first pulse occurs SAMPLE_DIV cycles after enable rises.
  - enable=0 holds the counter at 0 and keeps sample_en at 0.
- Error magnitude: |er| computed in 32 bits; er=-2^31 saturates to 2^31-1. Good = |er| <= LOCK_THRESH.
- Outputs loop_hold, kp_shift, ki_shift, locked and state are Moore outputs decoded from the state register. They change in the same cycle the state register changes.
- IDLE: loop_hold=1, ACQ gains, locked=0. enable=1 -> FLUSH next edge.
- FLUSH: loop_hold=1, ACQ gains.
  - Counts strobe pulses.
  - Goes to ACQ on the edge where the FLUSH_SYMS-th strobe is sampled.
  - ted_out_en is ignored.
- ACQ: loop_hold=0, ACQ gains, locked=0. On each ted_out_en:
  - sym_cnt increments.
  - A good symbol increments good_cnt; a bad symbol clears it.
  - When good_cnt reaches LOCK_COUNT -> TRACK.
  - Otherwise, when sym_cnt reaches ACQ_TIMEOUT -> FLUSH, with acq_timeout=1 for one cycle.
  - If both conditions hit on the same event, lock wins.
- TRACK: loop_hold=0, TRK gains, locked=1. On each ted_out_en:
  - A bad symbol increments bad_cnt; a good symbol clears it.
  - When bad_cnt reaches UNLOCK_COUNT -> ACQ.
- Counter clearing: every state entry clears flush_cnt, sym_cnt, good_cnt and bad_cnt. Counters saturate and never wrap.
- Priority: reset > enable=0 (-> IDLE next edge from any state, all counters cleared) > state transitions.
- strobe outside FLUSH and ted_out_en outside ACQ/TRACK have no effect.
- ted_out_en coincident with a transition edge is consumed by the current state only.
- Counter widths are $clog2(param+1).

Decomposition:
- Shared package str_pkg:
  - state enum (IDLE/FLUSH/ACQ/TRACK, 2-bit)
  - default gain shift constants
  - TED error width constant 32
- One sub-module str_run_counter: abs-saturate, threshold compare, consecutive good/bad run counters. Instantiated once; run counters are cleared by the parent.

Test Plan:
- Parameter overrides used below: SAMPLE_DIV=10, FLUSH_SYMS=4, LOCK_COUNT=8, UNLOCK_COUNT=3, ACQ_TIMEOUT=20.
- Reset, then enable=1 -> sample_en pulses every 10 cycles, first at cycle 10 after enable. state=1 until 4th strobe, then state=2, loop_hold=0, kp_shift=4, ki_shift=10.
- In ACQ, 8 ted_out_en with er=100 -> state=3, locked=1, kp_shift=7, ki_shift=14. The same run with er=-5000 at the 5th event needs 8 further good events.
- In ACQ, 20 ted_out_en with er=5000 -> acq_timeout single pulse, state=1, loop_hold=1, counters cleared.
- In TRACK: bad, bad, good, bad, bad -> stays locked. Bad, bad, bad -> state=2, locked=0.
- er=32'h80000000 in ACQ counts as bad (no overflow to negative). er=+/-4096 counts as good.
- enable dropped in TRACK, simultaneous with ted_out_en -> state=0, loop_hold=1, locked=0 next edge, sample_en stops. reset asserted mid-ACQ -> all outputs at reset values next edge.
